rf_wb_scheduler: RTL

//  Writeback scheduler and scoreboard in front of the RV32 32x32 register file write port.

---
 rtl/rf_wb_scheduler_if.sv | 36 +++
 rtl/rf_wb_scheduler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of issue, writeback and register-file-port signals for rf_wb_scheduler.
interface rf_wb_scheduler_if #(
  parameter int unsigned XLEN = 32
);
  logic            iss_valid;
  logic            iss_long;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_ready;
  logic            alu_wvalid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            lsu_wvalid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            lsu_wready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     sb_busy;

  modport master (
    output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
    output alu_wvalid, alu_rd, alu_wdata,
    output lsu_wvalid, lsu_rd, lsu_wdata,
    input  iss_ready, lsu_wready, rf_we, rf_rd, rf_wdata, sb_busy
  );

  modport slave (
    input  iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
    input  alu_wvalid, alu_rd, alu_wdata,
    input  lsu_wvalid, lsu_rd, lsu_wdata,
    output iss_ready, lsu_wready, rf_we, rf_rd, rf_wdata, sb_busy
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the single register-file write port: round-robin between the
// ALU path (skid FIFO head or live ALU result) and the LSU/MDU path, plus a pending-write
// scoreboard that stalls issue on RAW/WAW hazards or when the ALU skid FIFO could overflow.
module rf_wb_scheduler #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  rf_wb_scheduler_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            alu_pend_q, rr_q, rr_d;
  logic            rf_we_q;
  logic [4:0]      rf_rd_q, win_rd;
  logic [XLEN-1:0] rf_wdata_q, win_data;
  logic [31:0]     busy_q, busy_d;

  logic alu_req, h_req, ha_req, l_req, l_drop, tie, grant_l, grant_ha, grant;
  logic enq, deq, hazard, fifo_ok, iss_ready, issue;

  // Arbitration, FIFO control and winner selection.
  always_comb begin
    // Results for x0 need no port slot; an ALU result without a matching issue is ignored.
    alu_req  = bus.alu_wvalid & alu_pend_q & (bus.alu_rd != 5'd0);
    h_req    = (count_q != '0);
    ha_req   = h_req | alu_req;
    l_req    = bus.lsu_wvalid & (bus.lsu_rd != 5'd0);
    l_drop   = bus.lsu_wvalid & (bus.lsu_rd == 5'd0);
    tie      = ha_req & l_req;
    grant_l  = l_req & (!ha_req | !rr_q);
    grant_ha = ha_req & (!l_req | rr_q);
    grant    = grant_l | grant_ha;
    // Once the FIFO is non-empty, live ALU results queue behind it to keep order.
    enq      = alu_req & (h_req | !grant_ha);
    deq      = h_req & grant_ha;
    rr_d     = tie ? grant_l : rr_q;
    win_rd   = bus.lsu_rd;
    win_data = bus.lsu_wdata;
    if (grant_ha) begin
      win_rd   = h_req ? fifo_rd[head_q] : bus.alu_rd;
      win_data = h_req ? fifo_data[head_q] : bus.alu_wdata;
    end
    head_d  = deq ? ((head_q == PtrW'(DEPTH - 1)) ? '0 : head_q + 1'b1) : head_q;
    tail_d  = enq ? ((tail_q == PtrW'(DEPTH - 1)) ? '0 : tail_q + 1'b1) : tail_q;
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Issue gating and scoreboard next state; hazards use the registered busy vector.
  always_comb begin
    hazard = (busy_q[bus.iss_rs1] & (bus.iss_rs1 != 5'd0)) |
             (busy_q[bus.iss_rs2] & (bus.iss_rs2 != 5'd0)) |
             (busy_q[bus.iss_rd]  & (bus.iss_rd  != 5'd0));
    // Reserve a FIFO slot for every ALU result still in flight.
    fifo_ok   = (32'(count_q) + 32'(alu_pend_q)) < DEPTH;
    iss_ready = !hazard & (bus.iss_long | fifo_ok);
    issue     = bus.iss_valid & iss_ready;
    busy_d    = busy_q;
    if (grant) begin
      busy_d[win_rd] = 1'b0;
    end
    if (issue && (bus.iss_rd != 5'd0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Control state, registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      alu_pend_q <= 1'b0;
      rr_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      alu_pend_q <= issue & !bus.iss_long;
      rr_q       <= rr_d;
      rf_we_q    <= grant;
      if (grant) begin
        rf_rd_q    <= win_rd;
        rf_wdata_q <= win_data;
      end
      busy_q     <= busy_d;
    end
  end

  // Skid FIFO storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[tail_q]   <= bus.alu_rd;
      fifo_data[tail_q] <= bus.alu_wdata;
    end
  end

  assign bus.iss_ready  = iss_ready;
  assign bus.lsu_wready = grant_l | l_drop;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.sb_busy    = busy_q;
endmodule
